// File: rtl/stack_cpu_console_if.sv
// CPU-facing signal bundle: the result/status outputs of the stack CPU and its single-step input.
interface stack_cpu_console_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] result;
    logic                  valid_result;
    logic                  error;
    logic                  halt;
    logic                  single_step;

    modport master (
        output result, valid_result, error, halt,
        input  single_step
    );

    modport slave (
        input  result, valid_result, error, halt,
        output single_step
    );
endinterface

// File: rtl/stack_cpu_console.sv
// Board console for the stack CPU: debounced step pulse, result/status capture, 8-digit hex scan.
// Step pulse lands DEBOUNCE_CYCLES+3 cycles after a stable press; no backpressure, inputs sampled every cycle.
module stack_cpu_console #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_CYCLES     = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_step,
    stack_cpu_console_if.slave   cpu,
    output logic [7:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 led_error,
    output logic                 led_halt,
    output logic [7:0]           result_count
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCW = $clog2(SCAN_CYCLES + 1);

    logic            btn_sync1, btn_sync2;
    logic            btn_deb, btn_deb_q;
    logic [DBW-1:0]  deb_cnt;
    logic            step_r;
    logic            valid_q;
    logic [15:0]     value;
    logic [SCW-1:0]  scan_cnt;
    logic [2:0]      idx;
    logic [6:0]      digit_seg;
    logic [DATA_WIDTH-1:0] res_w;

    assign res_w           = cpu.result;
    assign cpu.single_step = step_r;
    assign dp              = 1'b1;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: hex_font = 7'h40;
            4'h1: hex_font = 7'h79;
            4'h2: hex_font = 7'h24;
            4'h3: hex_font = 7'h30;
            4'h4: hex_font = 7'h19;
            4'h5: hex_font = 7'h12;
            4'h6: hex_font = 7'h02;
            4'h7: hex_font = 7'h78;
            4'h8: hex_font = 7'h00;
            4'h9: hex_font = 7'h10;
            4'hA: hex_font = 7'h08;
            4'hB: hex_font = 7'h03;
            4'hC: hex_font = 7'h46;
            4'hD: hex_font = 7'h21;
            4'hE: hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    // Button: two-flop synchronizer, stability counter, rising-edge pulse gated by sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            deb_cnt   <= '0;
            step_r    <= 1'b0;
        end else begin
            btn_sync1 <= btn_step;
            btn_sync2 <= btn_sync1;
            btn_deb_q <= btn_deb;
            step_r    <= btn_deb & ~btn_deb_q & ~led_error & ~led_halt;
            if (btn_sync2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_deb <= btn_sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Capture on the rising edge of valid_result so a held valid counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            value        <= '0;
            result_count <= '0;
            led_error    <= 1'b0;
            led_halt     <= 1'b0;
        end else begin
            valid_q <= cpu.valid_result;
            if (cpu.valid_result && !valid_q) begin
                value        <= 16'($signed(res_w));
                result_count <= result_count + 8'd1;
            end
            if (cpu.error) led_error <= 1'b1;
            if (cpu.halt)  led_halt  <= 1'b1;
        end
    end

    always_comb begin
        digit_seg = 7'h7F;
        case (idx)
            3'd0: digit_seg = hex_font(value[3:0]);
            3'd1: digit_seg = hex_font(value[7:4]);
            3'd2: digit_seg = hex_font(value[11:8]);
            3'd3: digit_seg = hex_font(value[15:12]);
            3'd4: digit_seg = hex_font(result_count[3:0]);
            3'd5: digit_seg = hex_font(result_count[7:4]);
            3'd7: begin
                if (led_error)     digit_seg = 7'b0000110;
                else if (led_halt) digit_seg = 7'b0001001;
            end
            default: digit_seg = 7'h7F;
        endcase
    end

    // an and seg are both registered from the same idx so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 8'hFE;
            seg      <= 7'b1000000;
        end else begin
            if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(8'd1 << idx);
            seg <= digit_seg;
        end
    end
endmodule

// File: tb/tb_stack_cpu_console.sv
// Directed bench for stack_cpu_console with short debounce and scan periods.
module tb_stack_cpu_console;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_step;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       led_error;
    logic       led_halt;
    logic [7:0] result_count;

    int n_checks = 0;
    int n_errors = 0;

    stack_cpu_console_if #(.DATA_WIDTH(16)) cpu_bus ();

    stack_cpu_console #(
        .DATA_WIDTH(16),
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_step(btn_step),
        .cpu(cpu_bus.slave),
        .an(an),
        .seg(seg),
        .dp(dp),
        .led_error(led_error),
        .led_halt(led_halt),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " step"},  32'(cpu_bus.single_step), 32'd0);
        check({tag, " an"},    32'(an), 32'hFE);
        check({tag, " seg"},   32'(seg), 32'h40);
        check({tag, " dp"},    32'(dp), 32'd1);
        check({tag, " lerr"},  32'(led_error), 32'd0);
        check({tag, " lhalt"}, 32'(led_halt), 32'd0);
        check({tag, " cnt"},   32'(result_count), 32'd0);
    endtask

    // Per-cycle check of single_step; pulse_at=0 means no pulse allowed.
    task automatic step_watch(input int cycles, input int pulse_at, input string tag);
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s c%0d", tag, n), 32'(cpu_bus.single_step), 32'(n == pulse_at));
        end
    endtask

    task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
        bit found = 1'b0;
        logic [7:0] want;
        want = ~(8'd1 << d);
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an == want) found = 1'b1;
        end
        if (!found) check({tag, " timeout"}, 32'(an), 32'(want));
        else        check(tag, 32'(seg), 32'(exp));
    endtask

    task automatic pulse_valid(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_bus.valid_result = 1'b1;
            @(negedge clk);
            cpu_bus.valid_result = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset                = 1'b1;
        btn_step             = 1'b0;
        cpu_bus.result       = '0;
        cpu_bus.valid_result = 1'b0;
        cpu_bus.error        = 1'b0;
        cpu_bus.halt         = 1'b0;

        // 1. reset
        do_reset(3);
        check_reset_state("rst");

        // 2. single press held 20 cycles, then release
        btn_step = 1'b1;
        step_watch(20, 7, "press");
        btn_step = 1'b0;
        step_watch(10, 0, "release");

        // 3. bouncing button
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            step_watch(2, 0, "bounce");
        end
        btn_step = 1'b0;
        repeat (8) @(negedge clk);

        // 4. -2 held valid for 3 cycles counts once
        cpu_bus.result       = 16'hFFFE;
        cpu_bus.valid_result = 1'b1;
        repeat (3) @(negedge clk);
        cpu_bus.valid_result = 1'b0;
        repeat (2) @(negedge clk);
        check("cnt_hold", 32'(result_count), 32'd1);
        check_digit(0, 7'h06, "neg2 d0");
        check_digit(1, 7'h0E, "neg2 d1");
        check_digit(2, 7'h0E, "neg2 d2");
        check_digit(3, 7'h0E, "neg2 d3");
        check_digit(4, 7'h79, "cnt d4");
        check_digit(5, 7'h40, "cnt d5");
        check_digit(6, 7'h7F, "blank d6");
        check_digit(7, 7'h7F, "blank d7");

        // 5. count wrap
        do_reset(2);
        pulse_valid(255);
        check("cnt255", 32'(result_count), 32'hFF);
        check_digit(4, 7'h0E, "cnt255 d4");
        check_digit(5, 7'h0E, "cnt255 d5");
        pulse_valid(1);
        check("cnt_wrap", 32'(result_count), 32'd0);

        // 6. capture and error together, then halt, press suppressed, reset clears
        do_reset(2);
        cpu_bus.result       = 16'h1234;
        cpu_bus.valid_result = 1'b1;
        cpu_bus.error        = 1'b1;
        @(negedge clk);
        cpu_bus.valid_result = 1'b0;
        cpu_bus.error        = 1'b0;
        repeat (5) @(negedge clk);
        check("err_cnt", 32'(result_count), 32'd1);
        check("err_led", 32'(led_error), 32'd1);
        check_digit(0, 7'h19, "1234 d0");
        check_digit(1, 7'h30, "1234 d1");
        check_digit(2, 7'h24, "1234 d2");
        check_digit(3, 7'h79, "1234 d3");
        check_digit(7, 7'h06, "err d7");
        cpu_bus.halt = 1'b1;
        @(negedge clk);
        cpu_bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_led", 32'(led_halt), 32'd1);
        check("err_sticky", 32'(led_error), 32'd1);
        check_digit(7, 7'h06, "err_pri d7");
        btn_step = 1'b1;
        step_watch(20, 0, "suppressed");
        btn_step = 1'b0;
        repeat (8) @(negedge clk);
        do_reset(2);
        check_reset_state("rst2");
        check_digit(7, 7'h7F, "rst2 d7");

        // halt alone shows 'H'
        cpu_bus.halt = 1'b1;
        @(negedge clk);
        cpu_bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_only led", 32'(led_halt), 32'd1);
        check("halt_only err", 32'(led_error), 32'd0);
        check_digit(7, 7'h09, "halt d7");

        // reset mid-debounce with button held through release
        do_reset(2);
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        do_reset(2);
        step_watch(20, 7, "requalify");
        btn_step = 1'b0;
        step_watch(10, 0, "requal_rel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
